// File: rtl/tdm_demux.sv
// Receive side of a 1-bit TDM link: locks onto frame_sync, steers each strobed bit
// into its slot and publishes the completed frame with a one-cycle valid pulse.
module tdm_demux #(
   parameter int CH   = 4,
   parameter int SELW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            din,
   input  logic            en,
   input  logic            frame_sync,
   input  logic            clr_err,
   output logic [SELW-1:0] sel,
   output logic [CH-1:0]   y,
   output logic            y_valid,
   output logic            sync_err
);

   typedef enum logic {
      S_HUNT,
      S_RUN
   } state_t;

   state_t          r_state;
   logic [SELW-1:0] r_sel;
   logic [CH-2:0]   r_shadow;
   logic [CH-1:0]   r_y;
   logic            r_y_valid;
   logic            r_sync_err;

   logic [CH-2:0]   w_shadow_wr;
   logic [CH-2:0]   w_shadow_restart;
   logic [SELW-1:0] w_sel_inc;
   logic            w_last;

   // Slot CH-1 is never stored in the shadow; it goes straight into y.
   always_comb begin
      w_shadow_wr = r_shadow;
      for (int k = 0; k < CH-1; k++) begin
         if (r_sel == SELW'(k)) w_shadow_wr[k] = din;
      end
      w_shadow_restart    = '0;
      w_shadow_restart[0] = din;
   end

   assign w_sel_inc = r_sel + SELW'(1);
   assign w_last    = (r_sel == SELW'(CH-1));

   // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_HUNT;
         r_sel      <= '0;
         r_shadow   <= '0;
         r_y        <= '0;
         r_y_valid  <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_y_valid <= 1'b0;
         // Clear first so an error detected on the same edge overrides it.
         if (clr_err) r_sync_err <= 1'b0;

         if (en) begin
            if (r_state == S_HUNT) begin
               if (frame_sync) begin
                  r_shadow <= w_shadow_restart;
                  r_sel    <= SELW'(1);
                  r_state  <= S_RUN;
               end
            end else begin
               if (frame_sync && (r_sel != '0)) begin
                  r_sync_err <= 1'b1;
                  r_shadow   <= w_shadow_restart;
                  r_sel      <= SELW'(1);
               end else if (frame_sync) begin
                  r_shadow <= w_shadow_wr;
                  r_sel    <= w_sel_inc;
               end else if (r_sel == '0) begin
                  r_sync_err <= 1'b1;
                  r_state    <= S_HUNT;
               end else if (w_last) begin
                  r_y       <= {din, r_shadow};
                  r_y_valid <= 1'b1;
                  r_sel     <= '0;
               end else begin
                  r_shadow <= w_shadow_wr;
                  r_sel    <= w_sel_inc;
               end
            end
         end
      end
   end

   assign sel      = r_sel;
   assign y        = r_y;
   assign y_valid  = r_y_valid;
   assign sync_err = r_sync_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (CH=4): expected frames are queued as stimulus
// is driven and compared whenever the DUT raises y_valid.
module tb_tdm_demux;

   localparam int CH   = 4;
   localparam int SELW = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            din = 1'b0;
   logic            en = 1'b0;
   logic            frame_sync = 1'b0;
   logic            clr_err = 1'b0;
   logic [SELW-1:0] sel;
   logic [CH-1:0]   y;
   logic            y_valid;
   logic            sync_err;

   int              n_checks = 0;
   int              n_errors = 0;
   int              n_valid = 0;
   logic [CH-1:0]   sb_q[$];

   tdm_demux #(.CH(CH), .SELW(SELW)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .en         (en),
      .frame_sync (frame_sync),
      .clr_err    (clr_err),
      .sel        (sel),
      .y          (y),
      .y_valid    (y_valid),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every valid pulse must match the oldest queued frame.
   always @(negedge clk) begin
      if (!rst && y_valid) begin
         n_valid++;
         if (sb_q.size() == 0) check("unexpected_valid", 32'(y), 32'hFFFF_FFFF);
         else check("frame_y", 32'(y), 32'(sb_q.pop_front()));
      end
   end

   task automatic slot(input logic fs, input logic d);
      en = 1'b1; frame_sync = fs; din = d;
      @(posedge clk); #1;
      en = 1'b0; frame_sync = 1'b0; din = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // d[k] is the bit sent in slot k; gap idle cycles between slots.
   task automatic frame(input logic [CH-1:0] d, input int gap);
      for (int k = 0; k < CH; k++) begin
         if (k == CH-1) sb_q.push_back(d);
         slot(k == 0, d[k]);
         if (k < CH-1) check("gap_sel", 32'(sel), k + 1);
         if (k < CH-1) idle(gap);
         if (k < CH-1 && gap > 0) check("gap_sel_hold", 32'(sel), k + 1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0;
      do_reset();
      check("rst_y", 32'(y), 0);
      check("rst_sel", 32'(sel), 0);
      check("rst_valid", 32'(y_valid), 0);
      check("rst_err", 32'(sync_err), 0);

      // Clean frame, back-to-back strobes: y = 4'b1101 on the 4th edge.
      sb_q.push_back(4'b1101);
      slot(1'b1, 1'b1); check("clean_sel1", 32'(sel), 1);
      slot(1'b0, 1'b0);
      slot(1'b0, 1'b1);
      slot(1'b0, 1'b1);
      check("clean_valid", 32'(y_valid), 1);
      check("clean_y", 32'(y), 32'b1101);
      check("clean_sel_wrap", 32'(sel), 0);
      idle(1);
      check("clean_valid_drop", 32'(y_valid), 0);
      check("clean_err", 32'(sync_err), 0);

      // Two back-to-back frames: exactly two pulses, CH cycles apart.
      v0 = n_valid;
      frame(4'b0101, 0);
      frame(4'b1010, 0);
      idle(1);
      check("b2b_pulses", 32'(n_valid - v0), 2);

      // Hunt: unsynced slots are ignored after reset.
      do_reset();
      v0 = n_valid;
      for (int i = 0; i < 3; i++) slot(1'b0, 1'b1);
      check("hunt_sel", 32'(sel), 0);
      check("hunt_no_valid", 32'(n_valid - v0), 0);
      frame(4'b0110, 0);
      idle(1);
      check("hunt_y", 32'(y), 32'b0110);
      check("hunt_err", 32'(sync_err), 0);

      // Strobe gaps stretch the frame without affecting it.
      v0 = n_valid;
      frame(4'b0011, 2);
      idle(2);
      check("gap_pulses", 32'(n_valid - v0), 1);
      check("gap_y", 32'(y), 32'b0011);

      // Early sync on slot 2 restarts the frame; broken frame never emerges.
      v0 = n_valid;
      slot(1'b1, 1'b0);
      slot(1'b0, 1'b1);
      check("early_pre_err", 32'(sync_err), 0);
      sb_q.push_back(4'b1001);
      slot(1'b1, 1'b1);
      check("early_err", 32'(sync_err), 1);
      check("early_sel", 32'(sel), 1);
      slot(1'b0, 1'b0);
      slot(1'b0, 1'b0);
      slot(1'b0, 1'b1);
      idle(1);
      check("early_pulses", 32'(n_valid - v0), 1);
      check("early_y", 32'(y), 32'b1001);

      // Missing sync drops to HUNT; clear works; set beats clear.
      clr_err = 1'b1; idle(1); clr_err = 1'b0;
      frame(4'b1110, 0);
      check("miss_pre_err", 32'(sync_err), 0);
      slot(1'b0, 1'b1);
      check("miss_err", 32'(sync_err), 1);
      check("miss_sel", 32'(sel), 0);
      slot(1'b0, 1'b1);
      check("miss_hunt_sel", 32'(sel), 0);
      clr_err = 1'b1; idle(1); clr_err = 1'b0;
      check("clr_err", 32'(sync_err), 0);
      slot(1'b1, 1'b0);
      slot(1'b0, 1'b0);
      clr_err = 1'b1;
      slot(1'b1, 1'b0);
      clr_err = 1'b0;
      check("set_wins", 32'(sync_err), 1);

      // Reset two slots into a frame: outputs clear asynchronously.
      slot(1'b0, 1'b1);
      check("midrst_sel_pre", 32'(sel), 2);
      #1 rst = 1'b1;
      #1;
      check("midrst_y", 32'(y), 0);
      check("midrst_sel", 32'(sel), 0);
      check("midrst_valid", 32'(y_valid), 0);
      check("midrst_err", 32'(sync_err), 0);
      idle(1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      frame(4'b1111, 0);
      idle(1);
      check("midrst_y_after", 32'(y), 32'b1111);

      check("sb_drain", 32'(sb_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
